// File: rtl/kpad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Optional auto-repeat is selected in kpad_scanner with KPAD_AUTOREPEAT_EN.
package kpad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kpad_state_t;

  localparam logic [3:0] COL_FIRST = 4'b0001;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/kpad_sync.sv
// Two-flop synchronizer for the raw, asynchronous keypad row lines.
module kpad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  // synchronizer next-state
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer flops
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'd0;
      sync_q <= 4'd0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/kpad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-cycle enable.
// Define KPAD_AUTOREPEAT_EN to re-pulse enable every REPEAT_CYCLES while a key is held.
module kpad_scanner
  import kpad_pkg::*;
#(
  parameter int SCAN_DIV        = 100_000,
  parameter int DEBOUNCE_CYCLES = 500_000
`ifdef KPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 5_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       enable
);

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         row_sync;
  kpad_state_t        state_q, state_d;
  logic [3:0]         col_drive_q, col_drive_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0]    db_q, db_d;
  logic [3:0]         cand_row_q, cand_row_d;
  logic [3:0]         cand_col_q, cand_col_d;
  logic [3:0]         key_row_q, key_row_d;
  logic [3:0]         key_col_q, key_col_d;
  logic               enable_q, enable_d;
  logic               key_bit_s;

`ifdef KPAD_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  kpad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (row_sync)
  );

  // Only the captured row line matters once a key is accepted.
  assign key_bit_s = ((row_sync & cand_row_q) != 4'd0);

  // FSM next-state, counters and output pulse
  always_comb begin
    state_d     = state_q;
    col_drive_d = col_drive_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    key_row_d   = key_row_q;
    key_col_d   = key_col_q;
    enable_d    = 1'b0;
`ifdef KPAD_AUTOREPEAT_EN
    rpt_d       = rpt_q;
`endif
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (onehot4(row_sync)) begin
            cand_row_d = row_sync;
            cand_col_d = col_drive_q;
            db_d       = '0;
            state_d    = DEBOUNCE;
          end else begin
            col_drive_d = next_col(col_drive_q);
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_sync == cand_row_q) begin
          if (db_q == DB_LAST) begin
            key_row_d = cand_row_q;
            key_col_d = cand_col_q;
            enable_d  = 1'b1;
            db_d      = '0;
            state_d   = HELD;
`ifdef KPAD_AUTOREPEAT_EN
            rpt_d     = '0;
`endif
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          db_d        = '0;
          dwell_d     = '0;
          col_drive_d = next_col(col_drive_q);
          state_d     = SCAN;
        end
      end
      HELD: begin
        if (!key_bit_s) begin
          db_d    = '0;
          state_d = RELEASE;
`ifdef KPAD_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          state_d = HELD;
`ifdef KPAD_AUTOREPEAT_EN
          if (rpt_q == RPT_LAST) begin
            rpt_d    = '0;
            enable_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
`endif
        end
      end
      RELEASE: begin
        if (key_bit_s) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          db_d        = '0;
          dwell_d     = '0;
          col_drive_d = next_col(col_drive_q);
          state_d     = SCAN;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: begin
        state_d     = SCAN;
        col_drive_d = COL_FIRST;
        dwell_d     = '0;
        db_d        = '0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_drive_q <= COL_FIRST;
      dwell_q     <= '0;
      db_q        <= '0;
      cand_row_q  <= 4'd0;
      cand_col_q  <= 4'd0;
      key_row_q   <= 4'd0;
      key_col_q   <= 4'd0;
      enable_q    <= 1'b0;
`ifdef KPAD_AUTOREPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_drive_q <= col_drive_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      key_row_q   <= key_row_d;
      key_col_q   <= key_col_d;
      enable_q    <= enable_d;
`ifdef KPAD_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign col_drive = col_drive_q;
  assign row       = key_row_q;
  assign col       = key_col_q;
  assign enable    = enable_q;

endmodule

// File: tb/tb_kpad_scanner.sv
// Scoreboard bench for kpad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32).
module tb_kpad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_drive, row, col;
  logic       enable;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
  } key_t;
  key_t exp_q[$];

  logic [3:0] last_row = 4'd0;
  logic [3:0] last_col = 4'd0;
`ifdef KPAD_AUTOREPEAT_EN
  int n_rpt = 0;
`endif

  kpad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
`ifdef KPAD_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES   (32)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_drive (col_drive),
    .row       (row),
    .col       (col),
    .enable    (enable)
  );

  always #5 clk = ~clk;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] col_at(input int k);
    logic [3:0] c;
    c = 4'b0001;
    return c << (k % 4);
  endfunction

  task automatic push_exp(input logic [3:0] r, input logic [3:0] c);
    key_t e;
    e.r = r;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Returns at the first negedge where col_drive has just become target.
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col_drive === target && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (col_drive !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_col: col_drive=%b never reached %b within 100 cycles", col_drive, target);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check4({tag, "_col_drive"}, col_drive, 4'b0001);
    check4({tag, "_row"}, row, 4'b0000);
    check4({tag, "_col"}, col, 4'b0000);
    check4({tag, "_enable"}, {3'b000, enable}, 4'b0000);
  endtask

  // monitor: every enable pulse must match the oldest expected key
  always @(negedge clk) begin
    key_t e;
    if (enable === 1'b1) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check4("enable_row", row, e.r);
        check4("enable_col", col, e.c);
        last_row <= e.r;
        last_col <= e.c;
      end
`ifdef KPAD_AUTOREPEAT_EN
      else if (row === last_row && col === last_col && row !== 4'd0) begin
        n_rpt++;
      end
`endif
      else begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable: got row=%b col=%b expected no enable", row, col);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    row_in = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // 1: idle rotation, one column every 4 cycles
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check4("idle_col", col_drive, col_at((i + 1) / 4));
    end

    // 2: clean press at column 0100, exact accept latency, frozen drive
    wait_col(4'b0100);
    push_exp(4'b0010, 4'b0100);
    row_in = 4'b0010;
    repeat (11) @(negedge clk);
    check4("t2_before_enable", {3'b000, enable}, 4'b0000);
    @(negedge clk);
    check4("t2_enable_latency", {3'b000, enable}, 4'b0001);
    @(negedge clk);
    check4("t2_enable_one_cycle", {3'b000, enable}, 4'b0000);
    repeat (40) @(negedge clk);
    check4("t2_frozen_a", col_drive, 4'b0100);
    repeat (46) @(negedge clk);
    check4("t2_frozen_b", col_drive, 4'b0100);
    row_in = 4'd0;
    repeat (20) @(negedge clk);
    check_int("t2_one_enable", exp_q.size(), 0);
    check4("t2_row_kept", row, 4'b0010);
    check4("t2_col_kept", col, 4'b0100);

    // 3: bouncing contact is never accepted, then a stable press is
    for (int k = 0; k < 10; k++) begin
      row_in = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (3) @(negedge clk);
    end
    row_in = 4'd0;
    wait_col(4'b0100);
    push_exp(4'b0010, 4'b0100);
    row_in = 4'b0010;
    repeat (20) @(negedge clk);
    check_int("t3_stable_enable", exp_q.size(), 0);
    row_in = 4'd0;
    repeat (20) @(negedge clk);

    // 4: second key while held is ignored; scan resumes from next column
    wait_col(4'b0100);
    push_exp(4'b0010, 4'b0100);
    row_in = 4'b0010;
    repeat (20) @(negedge clk);
    row_in = 4'b0110;
    repeat (20) @(negedge clk);
    row_in = 4'd0;
    repeat (10) @(negedge clk);
    check4("t4_still_frozen", col_drive, 4'b0100);
    @(negedge clk);
    check4("t4_resume_col", col_drive, 4'b1000);
    repeat (3) @(negedge clk);
    check4("t4_dwell", col_drive, 4'b1000);
    @(negedge clk);
    check4("t4_rotate", col_drive, 4'b0001);
    check_int("t4_no_extra", exp_q.size(), 0);

    // 5: short release glitch returns to HELD without a new enable
    wait_col(4'b0100);
    push_exp(4'b0010, 4'b0100);
    row_in = 4'b0010;
    repeat (20) @(negedge clk);
    row_in = 4'd0;
    repeat (3) @(negedge clk);
    row_in = 4'b0010;
    repeat (20) @(negedge clk);
    check4("t5_held", col_drive, 4'b0100);
    check_int("t5_no_new_enable", exp_q.size(), 0);
    row_in = 4'd0;
    repeat (20) @(negedge clk);

    // 6a: reset on the last DEBOUNCE cycle drops the pending enable
    wait_col(4'b0100);
    row_in = 4'b0010;
    repeat (11) @(negedge clk);
    reset  = 1'b1;
    row_in = 4'd0;
    @(negedge clk);
    check_reset_values("t6_debounce");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 6b: reset while HELD
    wait_col(4'b0100);
    push_exp(4'b0010, 4'b0100);
    row_in = 4'b0010;
    repeat (20) @(negedge clk);
    reset  = 1'b1;
    row_in = 4'd0;
    @(negedge clk);
    check_reset_values("t6_held");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_int("t6_queue", exp_q.size(), 0);

`ifdef KPAD_AUTOREPEAT_EN
    // 7: auto-repeat every 32 cycles while held
    wait_col(4'b0100);
    push_exp(4'b0010, 4'b0100);
    row_in = 4'b0010;
    repeat (12) @(negedge clk);
    check4("t7_accept", {3'b000, enable}, 4'b0001);
    for (int r = 0; r < 3; r++) begin
      repeat (31) @(negedge clk);
      check4("t7_gap", {3'b000, enable}, 4'b0000);
      @(negedge clk);
      check4("t7_repeat", {3'b000, enable}, 4'b0001);
      check4("t7_repeat_row", row, 4'b0010);
      check4("t7_repeat_col", col, 4'b0100);
    end
    check_int("t7_repeat_count", n_rpt >= 3 ? 1 : 0, 1);
    row_in = 4'd0;
    repeat (20) @(negedge clk);
`endif

    check_int("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
